// File: rtl/round_robin_fifo_dispatcher.sv
// Four-way round-robin dispatcher: one write stream fanned into four FIFOs,
// each drained by its own read enable with registered data and valid.
module round_robin_fifo_dispatcher #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  input  logic [3:0]       ren,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       valid,
  output logic             ready,
  output logic             error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [4][DEPTH];
  logic [PW-1:0]    r_rd  [4];
  logic [PW-1:0]    r_wr  [4];
  logic [CW-1:0]    r_cnt [4];
  logic [WIDTH-1:0] r_q   [4];
  logic [1:0]       r_rr;
  logic [3:0]       r_valid;
  logic             r_err;

  logic [3:0]       w_full;
  logic [3:0]       w_empty;
  logic [3:0]       w_wr;
  logic [3:0]       w_rd;
  logic [1:0]       w_tgt;
  logic             w_hit;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_full[i]  = (r_cnt[i] == CW'(DEPTH));
      w_empty[i] = (r_cnt[i] == '0);
    end
  end

  // Scan downward so the nearest non-full FIFO past r_rr wins.
  always_comb begin
    logic [1:0] v_idx;
    w_tgt = r_rr;
    w_hit = 1'b0;
    v_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      v_idx = r_rr + 2'(k);
      if (!w_full[v_idx]) begin
        w_hit = 1'b1;
        w_tgt = v_idx;
      end
    end
  end

  always_comb begin
    w_wr = '0;
    if (wen && w_hit)
      w_wr[w_tgt] = 1'b1;
    w_rd = ren & ~w_empty;
  end

  assign ready = w_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
        r_cnt[i] <= '0;
        r_q[i]   <= '0;
      end
      r_rr    <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr[i])
          r_wr[i] <= r_wr[i] + PW'(1);
        if (w_rd[i])
          r_rd[i] <= r_rd[i] + PW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_wr[i]) - CW'(w_rd[i]);
        r_q[i]   <= w_rd[i] ? r_mem[i][r_rd[i]] : '0;
      end
      r_valid <= w_rd;
      r_err   <= wen & ~w_hit;
      if (wen && w_hit)
        r_rr <= w_tgt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && w_wr[i])
        r_mem[i][r_wr[i]] <= din;
    end
  end

  assign a     = r_q[0];
  assign b     = r_q[1];
  assign c     = r_q[2];
  assign d     = r_q[3];
  assign valid = r_valid;
  assign error = r_err;

endmodule

// File: tb/tb_round_robin_fifo_dispatcher.sv
// Directed bench for round_robin_fifo_dispatcher: vector table
// plus hand sequences for fill, overflow, rotation and reset.
module tb_round_robin_fifo_dispatcher;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       wen;
  logic [3:0] ren;
  logic [7:0] a, b, c, d;
  logic [3:0] valid;
  logic       ready;
  logic       error;

  int total;
  int bad;

  round_robin_fifo_dispatcher #(.WIDTH(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .wen   (wen),
    .ren   (ren),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .valid (valid),
    .ready (ready),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       wen;
    logic [7:0] din;
    logic [3:0] ren;
    logic [7:0] ea, eb, ec, ed;
    logic [3:0] ev;
    logic       erdy;
    logic       eerr;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name,
                         input int ea, input int eb,
                         input int ec, input int ed,
                         input int ev, input int erdy,
                         input int eerr);
    chk({name, ".a"}, int'(a), ea);
    chk({name, ".b"}, int'(b), eb);
    chk({name, ".c"}, int'(c), ec);
    chk({name, ".d"}, int'(d), ed);
    chk({name, ".valid"}, int'(valid), ev);
    chk({name, ".ready"}, int'(ready), erdy);
    chk({name, ".error"}, int'(error), eerr);
  endtask

  task automatic cyc(input logic r, input logic w,
                     input logic [7:0] dv, input logic [3:0] rv);
    rst_n = r;
    wen   = w;
    din   = dv;
    ren   = rv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    wen   = 1'b0;
    din   = '0;
    ren   = '0;

    tv[0] = '{1'b0, 1'b0, 8'd0, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 1'b0};
    tv[1] = '{1'b1, 1'b1, 8'd1, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b1, 8'd2, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b1, 8'd3, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 1'b0};
    tv[4] = '{1'b1, 1'b1, 8'd4, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b1, 8'd5, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 8'd0, 4'b1111, 8'd1, 8'd2, 8'd3, 8'd4, 4'b1111, 1'b1, 1'b0};
    tv[7] = '{1'b1, 1'b0, 8'd0, 4'b0001, 8'd5, 8'd0, 8'd0, 8'd0, 4'b0001, 1'b1, 1'b0};
    tv[8] = '{1'b1, 1'b0, 8'd0, 4'b0001, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      cyc(tv[i].rst_n, tv[i].wen, tv[i].din, tv[i].ren);
      chk_all($sformatf("vec%0d", i),
              tv[i].ea, tv[i].eb, tv[i].ec, tv[i].ed,
              tv[i].ev, tv[i].erdy, tv[i].eerr);
    end

    // Fill all four FIFOs with 0..31.
    cyc(1'b0, 1'b0, 8'd0, 4'b0000);
    for (int v = 0; v < 32; v++) begin
      cyc(1'b1, 1'b1, 8'(v), 4'b0000);
      if (v == 30) chk("ready_before_full", int'(ready), 1);
    end
    chk_all("full", 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 8'd85, 4'b0000);
    chk_all("drop", 0, 0, 0, 0, 0, 0, 1);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk_all("drop_pulse_end", 0, 0, 0, 0, 0, 0, 0);

    // Free FIFO 2; the next write must skip full FIFOs 0 and 1.
    cyc(1'b1, 1'b0, 8'd0, 4'b0100);
    chk_all("free_c", 0, 0, 2, 0, 4'b0100, 1, 0);
    cyc(1'b1, 1'b1, 8'd139, 4'b0000);
    chk_all("wr139", 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 8'd0, 4'b1001);
    chk_all("free_ad", 0, 0, 0, 3, 4'b1001, 1, 0);
    // rr is 3 here, so 200 goes to FIFO 3 and 201 to FIFO 0.
    cyc(1'b1, 1'b1, 8'd200, 4'b0000);
    cyc(1'b1, 1'b1, 8'd201, 4'b0000);
    chk("full_again", int'(ready), 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 8'd0, 4'b1101);
      if (k < 7)
        chk_all($sformatf("drain%0d", k),
                4 + 4 * k, 0, 6 + 4 * k, 7 + 4 * k, 4'b1101, 1, 0);
      else
        chk_all("drain7", 201, 0, 139, 200, 4'b1101, 1, 0);
    end
    cyc(1'b1, 1'b0, 8'd0, 4'b1101);
    chk_all("drain_empty", 0, 0, 0, 0, 0, 1, 0);

    // Simultaneous read and write on FIFO 3 holding two entries.
    cyc(1'b0, 1'b0, 8'd0, 4'b0000);
    for (int v = 10; v <= 20; v++)
      cyc(1'b1, 1'b1, 8'(v), 4'b0000);
    cyc(1'b1, 1'b1, 8'd21, 4'b1000);
    chk_all("rw_same", 0, 0, 0, 13, 4'b1000, 1, 0);
    cyc(1'b1, 1'b0, 8'd0, 4'b1000);
    chk_all("rw_d1", 0, 0, 0, 17, 4'b1000, 1, 0);
    cyc(1'b1, 1'b0, 8'd0, 4'b1000);
    chk_all("rw_d2", 0, 0, 0, 21, 4'b1000, 1, 0);
    cyc(1'b1, 1'b0, 8'd0, 4'b1000);
    chk_all("rw_d3", 0, 0, 0, 0, 0, 1, 0);

    // Mid-stream reset with wen and ren active.
    cyc(1'b0, 1'b1, 8'd99, 4'b1111);
    chk_all("mid_rst", 0, 0, 0, 0, 0, 1, 0);
    cyc(1'b1, 1'b0, 8'd0, 4'b1111);
    chk_all("post_rst_rd", 0, 0, 0, 0, 0, 1, 0);
    cyc(1'b1, 1'b1, 8'd55, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b1111);
    chk_all("post_rst_wr", 55, 0, 0, 0, 4'b0001, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_robin_fifo_dispatcher.md
Name: round_robin_fifo_dispatcher

Overview:
Inverse of the round-robin FIFO arbiter. A single 8-bit write stream enters the block. Each accepted word goes into one of four per-channel FIFOs (a, b, c, d), with the target chosen round-robin among the non-full FIFOs. Each channel is drained independently by its own read enable, and each has a registered data output and a valid flag.

Parameters:
WIDTH, 8, data width of din and every channel output
DEPTH, 8, entries per channel FIFO (power of two, >= 2)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
din  input  WIDTH  write data
wen  input  1  write request for din this cycle
ren  input  4  per-channel read enable; bit0=a, bit1=b, bit2=c, bit3=d
a  output  WIDTH  channel 0 read data (registered)
b  output  WIDTH  channel 1 read data (registered)
c  output  WIDTH  channel 2 read data (registered)
d  output  WIDTH  channel 3 read data (registered)
valid  output  4  per-channel read-data valid (registered)
ready  output  1  combinational; 1 when at least one FIFO is not full
error  output  1  registered; one-cycle pulse when a write is dropped

Behaviour:
- Reset (rst_n=0 at posedge): all FIFOs empty (pointers and counts 0); rr pointer=0; a=b=c=d=0; valid=4'b0000; error=0. Reset overrides any wen/ren in the same cycle, including mid-operation: contents are discarded.
- Per FIFO: circular buffer with rd_ptr, wr_ptr and count (0..DEPTH). full=(count==DEPTH), empty=(count==0). Pointers wrap from DEPTH-1 to 0.
- Write target: the first non-full FIFO scanning from rr pointer upward, modulo 4 (e.g. rr=2 checks 2,3,0,1).
- Write accept: when wen=1 and ready=1, din is stored in the target FIFO at the posedge, and rr becomes (target+1) mod 4.
- wen=1 with all four FIFOs full: din is dropped, rr is unchanged, and error=1 in the following cycle.
- wen=0: rr unchanged.
- Read on channel i: when ren[i]=1 and FIFO i is not empty at the posedge, the head word goes to that channel's output register, valid[i]=1, and count decrements. Otherwise the channel output is 0 and valid[i]=0. Outputs never hold stale data.
- Read latency: one cycle. Written data is readable from the cycle after the write edge; ren at edge T gives data after edge T.
- Fullness and emptiness are evaluated on pre-edge state:
  - A read and write to the same FIFO in one cycle are both performed and count is unchanged.
  - A write to a full FIFO is skipped even if that FIFO is being read in the same cycle.
  - A read of an empty FIFO returns invalid even if that FIFO is being written in the same cycle.
- Channels are independent: any combination of ren bits is allowed in one cycle.
- ready depends only on full flags, never on wen or ren (no combinational path from ren).

Test Plan:
1. Reset, then write 1,2,3,4,5 on consecutive cycles (wen=1) -> entries land in FIFOs 0,1,2,3,0; ready stays 1; error stays 0.
2. After 1, ren=4'b1111 for one cycle -> next cycle a=1, b=2, c=3, d=4, valid=1111. Then ren=0001 -> a=5, valid=0001. Then ren=0001 -> a=0, valid=0000.
3. Reset, then 32 writes of values 0..31 -> ready=0 after the 32nd. A 33rd write (85) -> error=1 for exactly one cycle, no FIFO changed. Draining channel a 8 times yields 0,4,8,...,28.
4. All FIFOs full with rr=0: ren=0100 for one cycle frees FIFO 2 -> next write (139) goes to FIFO 2, skipping full 0 and 1; rr=3; ready returns to 0.
5. FIFO 3 holding 2 entries: wen=1 (target 3) together with ren=1000 in the same cycle -> d gets the head word, and FIFO 3 count stays 2.
6. Mid-stream reset: FIFOs partly filled, rst_n=0 for one cycle while wen=1 and ren=1111 -> valid=0000, a..d=0, error=0. Subsequent ren returns invalid until new writes occur, and the first new write goes to FIFO 0.
